// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encodings, FSM states and a
// constant-width helper used to size the shift-amount field.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_MUL = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU slice for the arithmetic and logic opcodes (ADD..NOT),
// producing the result together with its Z/N/C/V flags.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    flag_c = 1'b0;
    flag_v = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        flag_c = sum[WIDTH];
        flag_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // The extra MSB of the widened difference is set exactly when a < b.
        result = diff[WIDTH-1:0];
        flag_c = diff[WIDTH];
        flag_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      default: result = '0;
    endcase
  end

  assign flag_z = (result == '0);
  assign flag_n = result[WIDTH-1];

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; shifts and multiply iterate one
// step per cycle, other opcodes complete in a single cycle.
//
//   state  | meaning
//   S_IDLE | ready for a new operation
//   S_EXEC | iterating a shift or shift-add multiply
//   S_DONE | result and flags held until consumed
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy
);

  localparam int SW = clog2(WIDTH);
  localparam int CW = SW + 1;

  state_e           state;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    cnt;
  logic             is_mul;
  logic             shl_q;

  logic [WIDTH-1:0] comb_result;
  logic             comb_z, comb_n, comb_c, comb_v;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (comb_result),
    .flag_z (comb_z),
    .flag_n (comb_n),
    .flag_c (comb_c),
    .flag_v (comb_v)
  );

  logic [SW-1:0]    sh_amt;
  logic             op_legal;
  logic             op_is_shift;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nxt;
  logic [WIDTH-1:0] mul_lo_nxt;
  logic [WIDTH-1:0] shift_nxt;
  logic             shift_out;
  logic [WIDTH-1:0] exec_val;
  logic             exec_c;

  assign sh_amt      = b[SW-1:0];
  assign op_legal    = (op < 4'd8) || ((op == OP_MUL) && MUL_EN);
  assign op_is_shift = (op == OP_SHL) || (op == OP_SHR);

  // Shift-add step on {hi, lo}: lo starts as the multiplier and fills with
  // product bits from the top as the multiplier drains out of bit 0.
  assign mul_sum    = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mcand} : '0);
  assign mul_hi_nxt = mul_sum[WIDTH:1];
  assign mul_lo_nxt = {mul_sum[0], work_lo[WIDTH-1:1]};

  assign shift_nxt = shl_q ? {work_lo[WIDTH-2:0], 1'b0} : {1'b0, work_lo[WIDTH-1:1]};
  assign shift_out = shl_q ? work_lo[WIDTH-1] : work_lo[0];

  assign exec_val = is_mul ? mul_lo_nxt : shift_nxt;
  assign exec_c   = is_mul ? (|mul_hi_nxt) : shift_out;

  assign in_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      work_hi   <= '0;
      work_lo   <= '0;
      mcand     <= '0;
      cnt       <= '0;
      is_mul    <= 1'b0;
      shl_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (!op_legal) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= '0;
              flag_z    <= 1'b0;
              flag_n    <= 1'b0;
              flag_c    <= 1'b0;
              flag_v    <= 1'b0;
            end else if (op == OP_MUL) begin
              state   <= S_EXEC;
              busy    <= 1'b1;
              is_mul  <= 1'b1;
              work_hi <= '0;
              work_lo <= b;
              mcand   <= a;
              cnt     <= CW'(WIDTH);
            end else if (op_is_shift && (sh_amt == '0)) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= a;
              flag_z    <= (a == '0);
              flag_n    <= a[WIDTH-1];
              flag_c    <= 1'b0;
              flag_v    <= 1'b0;
            end else if (op_is_shift) begin
              state   <= S_EXEC;
              busy    <= 1'b1;
              is_mul  <= 1'b0;
              shl_q   <= (op == OP_SHL);
              work_lo <= a;
              cnt     <= {1'b0, sh_amt};
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= comb_result;
              flag_z    <= comb_z;
              flag_n    <= comb_n;
              flag_c    <= comb_c;
              flag_v    <= comb_v;
            end
          end
        end
        S_EXEC: begin
          if (is_mul) work_hi <= mul_hi_nxt;
          work_lo <= exec_val;
          cnt     <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            result    <= exec_val;
            flag_z    <= (exec_val == '0);
            flag_n    <= exec_val[WIDTH-1];
            flag_c    <= exec_c;
            flag_v    <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        flag_z, flag_n, flag_c, flag_v, busy;

  logic        in_valid0 = 1'b0;
  logic        in_ready0;
  logic        out_valid0;
  logic        out_ready0 = 1'b0;
  logic [15:0] result0;
  logic        z0, n0, c0, v0, busy0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .flag_v(flag_v), .busy(busy)
  );

  alu_seq #(.WIDTH(16), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .op(op), .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready0),
    .result(result0), .flag_z(z0), .flag_n(n0), .flag_c(c0),
    .flag_v(v0), .busy(busy0)
  );

  // Reference model: flags packed as {z, n, c, v}; bc = expected busy cycles.
  function automatic void model(input logic [3:0] opv, input logic [15:0] av,
                                input logic [15:0] bv, input bit mul_en,
                                output logic [15:0] r, output logic [3:0] f,
                                output int bc);
    int ai, bi, sa, sb, ss, s;
    longint full;
    bit c, v, legal;
    ai = int'(av);
    bi = int'(bv);
    sa = (ai >= 32768) ? ai - 65536 : ai;
    sb = (bi >= 32768) ? bi - 65536 : bi;
    s = bi % 16;
    c = 0; v = 0; legal = 1; bc = 0; r = '0;
    case (int'(opv))
      0: begin
        full = longint'(ai) + longint'(bi);
        r = 16'(full % 65536);
        c = (full > 65535);
        ss = sa + sb;
        v = (ss > 32767) || (ss < -32768);
      end
      1: begin
        r = 16'((ai - bi + 65536) % 65536);
        c = (ai < bi);
        ss = sa - sb;
        v = (ss > 32767) || (ss < -32768);
      end
      2: r = av & bv;
      3: r = av | bv;
      4: r = av ^ bv;
      5: r = 16'(65535 - ai);
      6: begin
        r = 16'((longint'(ai) * (longint'(1) << s)) % 65536);
        c = (s != 0) && (((ai >> (16 - s)) % 2) == 1);
        bc = s;
      end
      7: begin
        r = 16'(ai >> s);
        c = (s != 0) && (((ai >> (s - 1)) % 2) == 1);
        bc = s;
      end
      8: begin
        if (mul_en) begin
          full = longint'(ai) * longint'(bi);
          r = 16'(full % 65536);
          c = (full >= 65536);
          bc = 16;
        end else legal = 0;
      end
      default: legal = 0;
    endcase
    if (legal) f = {(r == 16'd0), r[15], c, v};
    else begin
      r = '0;
      f = 4'b0000;
    end
  endfunction

  task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] res, output logic [3:0] fl,
                       output int lat, output int bc);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    op = 4'($urandom);
    lat = 1;
    bc = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bc++;
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
    fl = {flag_z, flag_n, flag_c, flag_v};
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_total++;
    if ({out_valid, busy, in_ready} !== 3'b001) $display("FAIL reset_ctrl got %b exp 001", {out_valid, busy, in_ready});
    else n_pass++;
    n_total++;
    if ({result, flag_z, flag_n, flag_c, flag_v} !== 20'h0) $display("FAIL reset_data got %h exp 00000", {result, flag_z, flag_n, flag_c, flag_v});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_sub();
    logic [15:0] r; logic [3:0] f; int lat, bc;
    issue(4'd0, 16'hFF00, 16'h0101, r, f, lat, bc);
    n_total++;
    if ({r, f} !== {16'h0001, 4'b0010}) $display("FAIL add_carry got %h/%b exp 0001/0010", r, f); else n_pass++;
    n_total++;
    if (lat !== 1) $display("FAIL add_latency got %0d exp 1", lat); else n_pass++;
    consume();
    issue(4'd1, 16'd16, 16'd9, r, f, lat, bc);
    n_total++;
    if ({r, f} !== {16'd7, 4'b0000}) $display("FAIL sub_pos got %h/%b exp 0007/0000", r, f); else n_pass++;
    consume();
    issue(4'd1, 16'd9, 16'd16, r, f, lat, bc);
    n_total++;
    if ({r, f} !== {16'hFFF9, 4'b0110}) $display("FAIL sub_borrow got %h/%b exp fff9/0110", r, f); else n_pass++;
    consume();
  endtask

  task automatic test_logic_hold();
    logic [15:0] r; logic [3:0] f; int lat, bc;
    issue(4'd2, 16'hFF00, 16'h00FF, r, f, lat, bc);
    n_total++;
    if ({r, f} !== {16'h0000, 4'b1000}) $display("FAIL and_zero got %h/%b exp 0000/1000", r, f); else n_pass++;
    consume();
    issue(4'd3, 16'hAA00, 16'h5500, r, f, lat, bc);
    n_total++;
    if ({r, f} !== {16'hFF00, 4'b0100}) $display("FAIL or_neg got %h/%b exp ff00/0100", r, f); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 4'd0; a = 16'd1; b = 16'd1;
      @(posedge clk);
      #1;
      n_total++;
      if ({result, in_ready, out_valid} !== {16'hFF00, 2'b01})
        $display("FAIL hold_stable got %h/%b%b exp ff00/01", result, in_ready, out_valid);
      else n_pass++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume();
    @(posedge clk);
    #1;
    n_total++;
    if ({out_valid, in_ready} !== 2'b01) $display("FAIL hold_no_accept got %b exp 01", {out_valid, in_ready});
    else n_pass++;
  endtask

  task automatic test_shift();
    logic [15:0] r; logic [3:0] f; int lat, bc;
    issue(4'd6, 16'd1, 16'd15, r, f, lat, bc);
    n_total++;
    if ({r, f} !== {16'h8000, 4'b0100}) $display("FAIL shl15 got %h/%b exp 8000/0100", r, f); else n_pass++;
    n_total++;
    if (bc !== 15 || lat !== 16) $display("FAIL shl15_busy got %0d/%0d exp 15/16", bc, lat); else n_pass++;
    consume();
    issue(4'd7, 16'h0003, 16'd1, r, f, lat, bc);
    n_total++;
    if ({r, f} !== {16'h0001, 4'b0010}) $display("FAIL shr1 got %h/%b exp 0001/0010", r, f); else n_pass++;
    consume();
    issue(4'd6, 16'h1234, 16'd16, r, f, lat, bc);
    n_total++;
    if ({r, f, lat[7:0]} !== {16'h1234, 4'b0000, 8'd1}) $display("FAIL shl_zero got %h/%b/%0d exp 1234/0000/1", r, f, lat);
    else n_pass++;
    consume();
  endtask

  task automatic test_mul();
    logic [15:0] r; logic [3:0] f; int lat, bc;
    issue(4'd8, 16'd300, 16'd300, r, f, lat, bc);
    n_total++;
    if ({r, f} !== {16'h5F90, 4'b0010}) $display("FAIL mul_ovf got %h/%b exp 5f90/0010", r, f); else n_pass++;
    n_total++;
    if (bc !== 16) $display("FAIL mul_busy got %0d exp 16", bc); else n_pass++;
    consume();
    issue(4'd8, 16'd3, 16'd5, r, f, lat, bc);
    n_total++;
    if ({r, f} !== {16'd15, 4'b0000}) $display("FAIL mul_small got %h/%b exp 000f/0000", r, f); else n_pass++;
    consume();
  endtask

  task automatic test_mul_disabled();
    @(negedge clk);
    op = 4'd8; a = 16'd300; b = 16'd300; in_valid0 = 1'b1;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    n_total++;
    if ({out_valid0, result0, z0, n0, c0, v0} !== {1'b1, 16'h0, 4'b0000})
      $display("FAIL mul_disabled got %b/%h/%b exp 1/0000/0000", out_valid0, result0, {z0, n0, c0, v0});
    else n_pass++;
    @(negedge clk);
    out_ready0 = 1'b1;
    @(posedge clk);
    #1;
    out_ready0 = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] r, er, x, y; logic [3:0] f, ef, o; int lat, bc, ebc;
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      x = 16'($urandom);
      y = 16'($urandom);
      model(o, x, y, 1'b1, er, ef, ebc);
      issue(o, x, y, r, f, lat, bc);
      n_total++;
      if ({r, f} !== {er, ef}) $display("FAIL rand_op%0d got %h/%b exp %h/%b (a=%h b=%h)", o, r, f, er, ef, x, y);
      else n_pass++;
      n_total++;
      if (bc !== ebc || lat !== ebc + 1) $display("FAIL rand_timing op%0d got %0d/%0d exp %0d/%0d", o, bc, lat, ebc, ebc + 1);
      else n_pass++;
      consume();
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [15:0] r; logic [3:0] f; int lat, bc;
    @(negedge clk);
    op = 4'd8; a = 16'd300; b = 16'd300; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    n_total++;
    if (busy !== 1'b1) $display("FAIL abort_busy_before got %b exp 1", busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, busy, in_ready, result} !== {3'b001, 16'h0})
      $display("FAIL abort_clear got %b/%h exp 001/0000", {out_valid, busy, in_ready}, result);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if ({out_valid, in_ready} !== 2'b01) $display("FAIL abort_after got %b exp 01", {out_valid, in_ready}); else n_pass++;
    issue(4'd0, 16'd2, 16'd2, r, f, lat, bc);
    n_total++;
    if ({r, f, lat[7:0]} !== {16'd4, 4'b0000, 8'd1}) $display("FAIL abort_add got %h/%b/%0d exp 0004/0000/1", r, f, lat);
    else n_pass++;
    consume();
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic_hold();
    test_shift();
    test_mul();
    test_mul_disabled();
    test_random();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the 16-bit one-hot-select combinational ALU. It takes an encoded opcode with a valid/ready handshake and holds the result and status flags until they are consumed. Shifts and multiply run as multi-cycle iterative operations. It is the execution unit for the upcoming simple CPU datapath.

Parameters:
WIDTH, 16, operand/result width in bits (≥4, power of 2)
MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL treated as illegal

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request valid
in_ready  out  1  unit can accept an operation
op  in  4  opcode (see Behaviour)
a  in  WIDTH  operand A
b  in  WIDTH  operand B / shift amount
out_valid  out  1  result and flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
flag_z  out  1  result == 0
flag_n  out  1  result MSB
flag_c  out  1  carry/borrow/shift-out/mul-overflow
flag_v  out  1  signed overflow (ADD/SUB only)
busy  out  1  high in EXEC

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous assertion, active-low. Reset forces state=IDLE and clears result, all flags, out_valid and busy to 0. in_ready=1 while in IDLE.
- Opcodes: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 NOT (~a, b ignored), 6 SHL, 7 SHR (logical), 8 MUL (low WIDTH bits, unsigned). 9-15 illegal; MUL is also illegal when MUL_EN=0.
- FSM states: IDLE, EXEC, DONE. in_ready = (state==IDLE). An operation is accepted on a clk edge where in_valid && in_ready; a, b and op are latched there.
- Ops 0-5 and illegal ops: go IDLE->DONE at the accept edge. out_valid is high the cycle after acceptance (latency 1). Illegal ops produce result=0 and all flags 0.
- SHL/SHR: amount s = b[log2(WIDTH)-1:0]; upper bits of b are ignored. s=0: IDLE->DONE at accept, result=a, C=0. Otherwise IDLE->EXEC, then shift one bit per cycle for exactly s cycles, then DONE. C = last bit shifted out.
- MUL: shift-add, IDLE->EXEC, exactly WIDTH cycles in EXEC, then DONE. C=1 iff the upper WIDTH bits of the full product are nonzero. V=0.
- Flags: Z and N are computed from the final result for every legal op.
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = borrow (a<b unsigned); V = signed overflow.
  - Logic ops: C=V=0.
- DONE: out_valid=1. result and flags stay stable until out_ready. The edge with out_valid && out_ready returns to IDLE. Minimum issue interval is 2 cycles.
- in_valid during EXEC/DONE is ignored (not accepted). Inputs are not required to be stable after the accept edge.
- Reset mid-EXEC or mid-DONE aborts the operation with no output; all outputs return to reset values immediately.
- Width rules: all arithmetic is modulo 2^WIDTH. No X allowed on outputs after reset.

Decomposition:
- alu_pkg: opcode localparams/enum (OP_ADD..OP_MUL), FSM state enum, helper function clog2 for the shift-amount width.
- Sub-module alu_comb: the purely combinational unit for ops 0-5, producing result plus Z/N/C/V, instantiated once. alu_seq owns the FSM, operand/shift/MUL registers and output hold.

Test Plan:
- ADD a=65280 b=257 (WIDTH=16) -> one cycle later out_valid=1, result=16'h0001, C=1, Z=0, V=0.
- SUB a=16 b=9 -> result=7, C=0, N=0. Then SUB a=9 b=16 -> result=16'hFFF9, C=1, N=1.
- AND 16'hFF00 & 16'h00FF -> result=0, Z=1. OR 16'hAA00 | 16'h5500 -> 16'hFF00, N=1. Hold out_ready=0 for 5 cycles: result stable, in_ready=0, a new in_valid is not accepted.
- SHL a=1 b=15 -> busy for 15 cycles, result=16'h8000, N=1, C=0. SHR a=16'h0003 b=1 -> result=1, C=1. SHL with b=16 -> s=0, result=a, latency 1.
- MUL a=300 b=300 -> busy for exactly 16 cycles, result=16'h5F90, C=1. MUL a=3 b=5 -> 15, C=0. With MUL_EN=0 -> result=0, flags 0.
- Assert rst_n low on the 8th EXEC cycle of MUL -> outputs clear asynchronously, no out_valid. After release, in_ready=1 and ADD 2+2 yields 4.
